// File: rtl/word_serial_adder_if.sv
// word_serial_adder_if: operand-in and result-out streams of the word-serial adder.
interface word_serial_adder_if #(
  parameter int MAX_BEATS = 16,
  localparam int LW = $clog2(MAX_BEATS + 1)
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic          in_first;
  logic          in_last;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_sum;
  logic          out_last;
  logic          out_cout;
  logic          out_ovf;
  logic [LW-1:0] out_len;
  logic          out_err;
  modport master (
    output in_valid, in_a, in_b, in_first, in_last, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, out_len, out_err
  );
  modport slave (
    input  in_valid, in_a, in_b, in_first, in_last, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, out_len, out_err
  );
endinterface

// File: rtl/word_serial_adder.sv
// word_serial_adder: LSW-first multi-precision add/sub, one 32-bit word per beat, carry chained across beats.
module word_serial_adder #(
  parameter int MAX_BEATS = 16,
  localparam int LW = $clog2(MAX_BEATS + 1)
) (
  input logic clk,
  input logic rst_n,
  word_serial_adder_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state_q, state_d;
  logic          carry_q, carry_d, sub_q, sub_d, err_q, err_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic          out_cout_q, out_cout_d, out_ovf_q, out_ovf_d, out_err_q, out_err_d;
  logic [31:0]   out_sum_q, out_sum_d;
  logic [LW-1:0] out_len_q, out_len_d;
  logic          accept, start, sub, cin, cout, sat, err_cur;
  logic [31:0]   b_eff, sum;
  logic [16:0]   lo, hi0, hi1;
  logic [LW-1:0] cnt_cur;
  assign bus.in_ready  = !out_valid_q | bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_err   = out_err_q;
  // Carry-select core: upper half precomputed for both carries, picked by the lower half's carry.
  always_comb begin
    accept  = bus.in_valid & bus.in_ready;
    start   = bus.in_first | (state_q == IDLE);
    sub     = start ? bus.in_sub : sub_q;
    cin     = start ? bus.in_sub : carry_q;
    b_eff   = sub ? ~bus.in_b : bus.in_b;
    lo      = {1'b0, bus.in_a[15:0]} + {1'b0, b_eff[15:0]} + {16'b0, cin};
    hi0     = {1'b0, bus.in_a[31:16]} + {1'b0, b_eff[31:16]};
    hi1     = {1'b0, bus.in_a[31:16]} + {1'b0, b_eff[31:16]} + 17'd1;
    {cout, sum} = {lo[16] ? hi1 : hi0, lo[15:0]};
    sat     = cnt_q == LW'(MAX_BEATS);
    cnt_cur = start ? LW'(1) : (sat ? cnt_q : cnt_q + LW'(1));
    err_cur = start ? (!bus.in_first | (state_q == BUSY)) : (err_q | sat);
  end
  always_comb begin
    state_d     = accept ? (bus.in_last ? IDLE : BUSY) : state_q;
    carry_d     = accept ? (!bus.in_last & cout) : carry_q;
    sub_d       = accept ? sub : sub_q;
    cnt_d       = accept ? (bus.in_last ? '0 : cnt_cur) : cnt_q;
    err_d       = accept ? (!bus.in_last & err_cur) : err_q;
    out_valid_d = accept | (out_valid_q & !bus.out_ready);
    out_sum_d   = accept ? sum : out_sum_q;
    out_last_d  = accept ? bus.in_last : out_last_q;
    out_cout_d  = accept ? (bus.in_last & (cout ^ sub)) : out_cout_q;
    out_ovf_d   = accept ? (bus.in_last & (bus.in_a[31] == b_eff[31]) & (sum[31] != bus.in_a[31])) : out_ovf_q;
    out_len_d   = accept ? (bus.in_last ? cnt_cur : '0) : out_len_q;
    out_err_d   = accept ? (bus.in_last & err_cur) : out_err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_len_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_len_q   <= out_len_d;
      out_err_q   <= out_err_d;
    end
  end
endmodule

// File: tb/tb_word_serial_adder.sv
// tb_word_serial_adder: directed vectors plus hand sequences for multi-beat, backpressure, malformed and reset cases.
module tb_word_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  word_serial_adder_if #(.MAX_BEATS(16)) bus ();
  word_serial_adder #(.MAX_BEATS(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  typedef struct packed {
    logic [31:0] sum;
    logic        last, cout, ovf;
    logic [4:0]  len;
    logic        err;
  } beat_t;
  typedef struct {
    logic [31:0] a, b;
    logic        sub;
    logic [31:0] sum;
    logic        cout, ovf;
  } vec_t;
  beat_t got[$];
  beat_t exp_q[$];
  int pass_cnt = 0;
  int tot_cnt = 0;
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready)
      got.push_back('{bus.out_sum, bus.out_last, bus.out_cout, bus.out_ovf, bus.out_len, bus.out_err});
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tot_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic f, input logic l, input logic s);
    logic acc = 1'b0;
    int n = 0;
    bus.in_a = a; bus.in_b = b; bus.in_first = f; bus.in_last = l; bus.in_sub = s; bus.in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("accept timeout", 64'(acc), 64'd1);
  endtask
  task automatic flush(input string name);
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk({name, " count"}, 64'(got.size()), 64'(exp_q.size()));
    n = got.size() < exp_q.size() ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s beat %0d", name, i), {23'b0, got[i]}, {23'b0, exp_q[i]});
    got.delete();
    exp_q.delete();
  endtask
  vec_t vecs[8];
  initial begin
    vecs[0] = '{32'd5,        32'd7,        1'b1, 32'hFFFFFFFE, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFFFFFF, 32'd1,        1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[2] = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[3] = '{32'h80000000, 32'd1,        1'b1, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[4] = '{32'd7,        32'd5,        1'b1, 32'h00000002, 1'b0, 1'b0};
    vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[6] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[7] = '{32'd0,        32'd0,        1'b1, 32'h00000000, 1'b0, 1'b0};
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.in_first = 1'b0; bus.in_last = 1'b0; bus.in_sub = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset out_sum", 64'(bus.out_sum), 64'd0);
    chk("reset out_len", 64'(bus.out_len), 64'd0);
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, 1'b1, 1'b1, vecs[i].sub);
      exp_q.push_back('{vecs[i].sum, 1'b1, vecs[i].cout, vecs[i].ovf, 5'd1, 1'b0});
    end
    flush("single");
    send(32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0);
    send(32'd1, 32'd0, 1'b0, 1'b1, 1'b1);
    exp_q.push_back('{32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0});
    exp_q.push_back('{32'h2, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0});
    flush("add2");
    send(32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    fork
      send(32'hFFFFFFFE, 32'd1, 1'b0, 1'b0, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          #2;
          chk("bp in_ready", 64'(bus.in_ready), 64'd0);
          chk("bp out_valid", 64'(bus.out_valid), 64'd1);
          chk("bp out_sum held", 64'(bus.out_sum), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    send(32'h10, 32'd0, 1'b0, 1'b0, 1'b0);
    send(32'h7FFFFFFF, 32'd1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back('{32'h1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0});
    exp_q.push_back('{32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0});
    exp_q.push_back('{32'h11, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0});
    exp_q.push_back('{32'h80000000, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0});
    flush("backpressure");
    for (int i = 0; i < 17; i++) begin
      send(32'(i + 1), 32'd0, i == 0, i == 16, 1'b0);
      exp_q.push_back('{32'(i + 1), i == 16, 1'b0, 1'b0, (i == 16) ? 5'd16 : 5'd0, i == 16});
    end
    flush("long17");
    send(32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
    send(32'd3, 32'd4, 1'b1, 1'b0, 1'b0);
    send(32'd5, 32'd6, 1'b0, 1'b1, 1'b0);
    exp_q.push_back('{32'd3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0});
    exp_q.push_back('{32'd7, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0});
    exp_q.push_back('{32'd11, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1});
    send(32'd10, 32'd3, 1'b0, 1'b1, 1'b1);
    exp_q.push_back('{32'd7, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1});
    flush("malformed");
    send(32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0);
    send(32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('{32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0});
    #1 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("async rst out_last", 64'(bus.out_last), 64'd0);
    chk("async rst out_sum", 64'(bus.out_sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
    exp_q.push_back('{32'd2, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0});
    flush("reset");
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
